// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the CPU memory stage (port 0)
// and a loader/DMA requester (port 1). One latched command per SERVE cycle, one-cycle ack.
module ram_arbiter #(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 rw0,
  input  logic [3:0]           sel0,
  input  logic [ADDR_BITS-3:0] addr0,
  input  logic [31:0]          wdata0,
  input  logic                 req1,
  input  logic                 rw1,
  input  logic [3:0]           sel1,
  input  logic [ADDR_BITS-3:0] addr1,
  input  logic [31:0]          wdata1,
  output logic                 ack0,
  output logic [31:0]          rdata0,
  output logic                 ack1,
  output logic [31:0]          rdata1,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic                 ram_rw,
  output logic [3:0]           ram_sel,
  output logic [ADDR_BITS-3:0] ram_addr,
  output logic [31:0]          ram_data_in,
  input  logic [31:0]          ram_data_out
);

  localparam int unsigned AW = ADDR_BITS - 2;

  typedef enum logic {StIdle, StServe} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            rw_q, rw_d;
  logic [3:0]      sel_q, sel_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            last_q, last_d;
  logic            ack0_q, ack0_d, ack1_q, ack1_d;
  logic [31:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic elig0, elig1, load, load_port;

  always_comb begin
    // A port's ack cycle masks its (possibly stale) request.
    elig0     = req0 & ~ack0_q;
    elig1     = req1 & ~ack1_q;
    state_d   = state_q;
    owner_d   = owner_q;
    rw_d      = rw_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    last_d    = last_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    load      = 1'b0;
    load_port = (elig0 && elig1) ? ~last_q : elig1;

    unique case (state_q)
      StIdle: begin
        if (elig0 || elig1) begin
          load    = 1'b1;
          state_d = StServe;
        end
      end
      StServe: begin
        last_d = owner_q;
        if (!owner_q) begin
          ack0_d = 1'b1;
          if (!rw_q) rdata0_d = ram_data_out;
        end else begin
          ack1_d = 1'b1;
          if (!rw_q) rdata1_d = ram_data_out;
        end
        load_port = ~owner_q;
        if (owner_q ? elig0 : elig1) begin
          load = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      owner_d = load_port;
      rw_d    = load_port ? rw1 : rw0;
      sel_d   = load_port ? sel1 : sel0;
      addr_d  = load_port ? addr1 : addr0;
      wdata_d = load_port ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      rw_q     <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      last_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rw_q     <= rw_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      last_q   <= last_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    busy        = (state_q == StServe);
    grant       = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    ram_rw      = busy & rw_q;
    ram_sel     = busy ? sel_q : 4'b0000;
    ram_addr    = busy ? addr_q : '0;
    ram_data_in = busy ? wdata_q : 32'h0;
    ack0        = ack0_q;
    ack1        = ack1_q;
    rdata0      = rdata0_q;
    rdata1      = rdata1_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, per-port expected-result queues
// popped on each ack, plus scenario tasks for latency, contention, fairness and reset.
module tb_ram_arbiter;

  localparam int unsigned ADDR_BITS = 12;
  localparam int unsigned AW = ADDR_BITS - 2;

  logic          clk, rst;
  logic          req0, rw0, req1, rw1;
  logic [3:0]    sel0, sel1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          ack0, ack1, busy, ram_rw;
  logic [31:0]   rdata0, rdata1, ram_data_in, ram_data_out;
  logic [1:0]    grant;
  logic [3:0]    ram_sel;
  logic [AW-1:0] ram_addr;

  logic [31:0] mem [1 << AW];

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ack_order[$];
  int   tests = 0;
  int   fails = 0;

  ram_arbiter #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rw0(rw0), .sel0(sel0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .rw1(rw1), .sel1(sel1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1),
    .grant(grant), .busy(busy),
    .ram_rw(ram_rw), .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: byte-lane write on the clock edge, combinational read.
  always @(posedge clk) begin
    if (ram_rw) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_sel[b]) mem[ram_addr][8*b +: 8] <= ram_data_in[8*b +: 8];
      end
    end
  end
  assign ram_data_out = mem[ram_addr];

  task automatic scoreboard_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      tests++;
      if (ack0 && ack1) begin
        fails++;
        $display("FAIL ack_exclusive: ack0=%b ack1=%b, required not both high", ack0, ack1);
      end
      tests++;
      if (ram_rw && !busy) begin
        fails++;
        $display("FAIL rw_outside_serve: ram_rw=%b busy=%b", ram_rw, busy);
      end
      if (ack0) begin
        tests++;
        ack_order.push_back(0);
        if (q0.size() == 0) begin
          fails++;
          $display("FAIL ack0_spurious: ack0=1 with no outstanding port 0 request");
        end else begin
          e = q0.pop_front();
          if (e.chk && rdata0 !== e.data) begin
            fails++;
            $display("FAIL rdata0: got %h, required %h", rdata0, e.data);
          end
        end
      end
      if (ack1) begin
        tests++;
        ack_order.push_back(1);
        if (q1.size() == 0) begin
          fails++;
          $display("FAIL ack1_spurious: ack1=1 with no outstanding port 1 request");
        end else begin
          e = q1.pop_front();
          if (e.chk && rdata1 !== e.data) begin
            fails++;
            $display("FAIL rdata1: got %h, required %h", rdata1, e.data);
          end
        end
      end
    end
  endtask

  // Issue one command on a port, push its expectation, wait (bounded) for the ack.
  task automatic op(input int port, input logic rw, input logic [3:0] sel,
                    input logic [AW-1:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_rd, output int lat);
    exp_t e;
    e.chk  = !rw;
    e.data = exp_rd;
    @(posedge clk);
    #1;
    if (port == 0) begin
      q0.push_back(e);
      req0 = 1'b1; rw0 = rw; sel0 = sel; addr0 = addr; wdata0 = wdata;
    end else begin
      q1.push_back(e);
      req1 = 1'b1; rw1 = rw; sel1 = sel; addr1 = addr; wdata1 = wdata;
    end
    lat = 0;
    forever begin
      @(negedge clk);
      if ((port == 0) ? ack0 : ack1) break;
      lat++;
      if (lat > 20) begin
        tests++;
        fails++;
        $display("FAIL ack_timeout: port %0d got no ack within 20 cycles", port);
        break;
      end
    end
    if (port == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    req0 = 1'b1; rw0 = 1'b0; sel0 = 4'hF; addr0 = 10'd0;
    @(posedge clk);
    #2;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_busy_before: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({ack0, ack1, rdata0, rdata1, grant, busy, ram_rw, ram_sel, ram_addr, ram_data_in}
        !== 116'h0) begin
      fails++;
      $display("FAIL reset_outputs: ack=%b%b grant=%b busy=%b rw=%b sel=%h addr=%h din=%h",
               ack0, ack1, grant, busy, ram_rw, ram_sel, ram_addr, ram_data_in);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || ack0 !== 1'b0 || grant !== 2'b00) begin
      fails++;
      $display("FAIL reset_held: busy=%b ack0=%b grant=%b, required 0/0/00", busy, ack0, grant);
    end
    req0 = 1'b0;
    rst  = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || grant !== 2'b00) begin
      fails++;
      $display("FAIL reset_idle_after: busy=%b grant=%b, required 0/00", busy, grant);
    end
  endtask

  task automatic test_write_read();
    int lat;
    op(0, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 32'h0, lat);
    tests++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL write_latency: got %0d, required 2", lat);
    end
    op(0, 1'b0, 4'hF, 10'd5, 32'h0, 32'hDEADBEEF, lat);
    tests++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL read_latency: got %0d, required 2", lat);
    end
    @(negedge clk);
    tests++;
    if (rdata0 !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL rdata0_held: got %h, required deadbeef", rdata0);
    end
  endtask

  task automatic test_contention();
    int lat0, lat1;
    logic [1:0] g [3];
    apply_reset();
    fork
      op(0, 1'b1, 4'hF, 10'd7, 32'hA5A5A5A5, 32'h0, lat0);
      op(1, 1'b0, 4'hF, 10'd5, 32'h0, 32'hDEADBEEF, lat1);
      begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          g[k] = grant;
        end
      end
    join
    tests++;
    if (g[0] !== 2'b00 || g[1] !== 2'b01 || g[2] !== 2'b10) begin
      fails++;
      $display("FAIL contention_grant: got %b,%b,%b, required 00,01,10", g[0], g[1], g[2]);
    end
    tests++;
    if (lat0 !== 2 || lat1 !== 3) begin
      fails++;
      $display("FAIL contention_latency: got %0d/%0d, required 2/3", lat0, lat1);
    end
  endtask

  task automatic test_fairness();
    ack_order.delete();
    fork
      for (int i = 0; i < 4; i++) begin
        int l;
        if (i % 2 == 0) op(0, 1'b1, 4'hF, 10'(20 + i), 32'h1000 + i, 32'h0, l);
        else op(0, 1'b0, 4'hF, 10'(19 + i), 32'h0, 32'h1000 + i - 1, l);
      end
      for (int j = 0; j < 4; j++) begin
        int l;
        if (j % 2 == 0) op(1, 1'b1, 4'hF, 10'(40 + j), 32'h2000 + j, 32'h0, l);
        else op(1, 1'b0, 4'hF, 10'(39 + j), 32'h0, 32'h2000 + j - 1, l);
      end
    join
    tests++;
    if (ack_order.size() != 8) begin
      fails++;
      $display("FAIL fairness_count: got %0d acks, required 8", ack_order.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        tests++;
        if (ack_order[k] != k % 2) begin
          fails++;
          $display("FAIL fairness_order[%0d]: got port %0d, required port %0d",
                   k, ack_order[k], k % 2);
        end
      end
    end
  endtask

  task automatic test_byte_lane();
    int lat;
    op(0, 1'b1, 4'hF, 10'd9, 32'h11223344, 32'h0, lat);
    op(1, 1'b1, 4'b0001, 10'd9, 32'h000000AB, 32'h0, lat);
    op(0, 1'b0, 4'hF, 10'd9, 32'h0, 32'h112233AB, lat);
  endtask

  task automatic test_reset_mid_serve();
    int   lat;
    exp_t e;
    op(0, 1'b1, 4'hF, 10'd30, 32'h55555555, 32'h0, lat);
    @(posedge clk);
    #1;
    req0 = 1'b1; rw0 = 1'b1; sel0 = 4'hF; addr0 = 10'd30; wdata0 = 32'hCAFEF00D;
    @(posedge clk);
    #2;
    tests++;
    if (busy !== 1'b1 || ram_rw !== 1'b1) begin
      fails++;
      $display("FAIL midserve_busy: busy=%b ram_rw=%b, required 1/1", busy, ram_rw);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || ram_rw !== 1'b0 || ack0 !== 1'b0) begin
      fails++;
      $display("FAIL midserve_reset: busy=%b ram_rw=%b ack0=%b, required 0", busy, ram_rw, ack0);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (mem[30] !== 32'h55555555) begin
      fails++;
      $display("FAIL midserve_mem: got %h, required 55555555", mem[30]);
    end
    rst = 1'b0;
    e.chk  = 1'b0;
    e.data = 32'h0;
    q0.push_back(e);
    lat = 0;
    forever begin
      @(negedge clk);
      if (ack0) break;
      lat++;
      if (lat > 20) begin
        tests++;
        fails++;
        $display("FAIL midserve_timeout: reissued write got no ack within 20 cycles");
        break;
      end
    end
    req0 = 1'b0;
    tests++;
    if (lat !== 1) begin
      fails++;
      $display("FAIL midserve_latency: got %0d, required 1", lat);
    end
    op(0, 1'b0, 4'hF, 10'd30, 32'h0, 32'hCAFEF00D, lat);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; rw0 = 1'b0; sel0 = 4'h0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; rw1 = 1'b0; sel1 = 4'h0; addr1 = '0; wdata1 = '0;
    fork
      scoreboard_monitor();
    join_none
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_contention();
    test_fairness();
    test_byte_lane();
    test_reset_mid_serve();
    repeat (3) @(negedge clk);
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL outstanding: %0d/%0d expectations left, required 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
